benes_cfg_loader: RTL and testbench

BENES_CFG_LOADER -- requirements
Module: benes_cfg_loader

---
 rtl/benes_cfg_loader.sv | 94 +++++++++
 tb/tb_benes_cfg_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_loader.sv
// Double-buffered configuration loader for a Benes network: frames fill a shadow
// bank and commit atomically. Optional readback port: BENES_CFG_READBACK_EN.
module benes_cfg_loader #(
  parameter  int NUM_STAGES = 7,
  parameter  int STAGE_W    = 8,
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STAGE_W-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               hold,
  output logic [STAGE_W-1:0] switch_set [NUM_STAGES],
  output logic               cfg_valid,
  output logic               cfg_update,
  output logic               err
`ifdef BENES_CFG_READBACK_EN
  ,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [STAGE_W-1:0] rd_data
`endif
);

  typedef enum logic [1:0] {LOAD, PEND, ERR} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [STAGE_W-1:0] shadow [NUM_STAGES];
  logic               accept;
  logic               last_idx;

  assign s_ready  = (state != PEND);
  assign accept   = s_valid && s_ready;
  assign last_idx = (idx == IDX_W'(NUM_STAGES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      idx        <= '0;
      cfg_valid  <= 1'b0;
      cfg_update <= 1'b0;
      err        <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        shadow[k]     <= '0;
        switch_set[k] <= '0;
      end
    end else begin
      cfg_update <= 1'b0;
      case (state)
        LOAD: if (accept) begin
          // A short frame's partial shadow is simply overwritten by the next frame.
          if (s_last && !last_idx) begin
            err <= 1'b1;
            idx <= '0;
          end else begin
            shadow[idx] <= s_data;
            if (last_idx) begin
              idx <= '0;
              if (s_last) state <= PEND;
              else begin
                err   <= 1'b1;
                state <= ERR;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ERR: if (accept && s_last) begin
          state <= LOAD;
          idx   <= '0;
        end
        PEND: if (!hold) begin
          for (int k = 0; k < NUM_STAGES; k++) switch_set[k] <= shadow[k];
          cfg_valid  <= 1'b1;
          cfg_update <= 1'b1;
          state      <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef BENES_CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rd_data <= '0;
    else if (32'(rd_idx) < NUM_STAGES)   rd_data <= switch_set[rd_idx];
    else                                 rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Scoreboard bench for benes_cfg_loader: expected frames queued when the final beat
// is driven, compared by a monitor on every cfg_update pulse.
module tb_benes_cfg_loader;
  localparam int NS = 7;
  localparam int W  = 8;
  typedef logic [NS-1:0][W-1:0] frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0, s_last = 1'b0, hold = 1'b0;
  logic         s_ready, cfg_valid, cfg_update, err;
  logic [W-1:0] switch_set [NS];
`ifdef BENES_CFG_READBACK_EN
  logic [2:0]   rd_idx = '0;
  logic [W-1:0] rd_data;
`endif

  int vectors = 0, miscompares = 0;
  frame_t exp_q[$];
  frame_t cur = '0;
  frame_t fa, fb;

  benes_cfg_loader #(.NUM_STAGES(NS), .STAGE_W(W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .hold(hold), .switch_set(switch_set), .cfg_valid(cfg_valid),
    .cfg_update(cfg_update), .err(err)
`ifdef BENES_CFG_READBACK_EN
    , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic frame_t pack_set();
    frame_t f;
    for (int k = 0; k < NS; k++) f[k] = switch_set[k];
    return f;
  endfunction

  // Monitor: every commit must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && cfg_update) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_commit: switch_set=%h, no frame expected", pack_set());
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (pack_set() !== e) begin
          miscompares++;
          $display("FAIL commit_data: got %h expected %h", pack_set(), e);
        end
        cur = e;
      end
    end
  end

  task automatic beat(input logic [W-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    while (!s_ready && t < 50) begin @(negedge clk); t++; end
    if (!s_ready) begin
      miscompares++;
      $display("FAIL ready_timeout: s_ready=0 required 1");
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // n words, last on the n-th; words beyond the frame use filler data
  task automatic send_words(input frame_t f, input int n);
    for (int k = 0; k < n; k++)
      beat((k < NS) ? f[k] : W'(8'hA0 + k), (k == n - 1));
  endtask

  task automatic wait_commit();
    int t = 0;
    while (!cfg_update && t < 20) begin @(negedge clk); t++; end
    vectors++;
    if (!cfg_update) begin
      miscompares++;
      $display("FAIL commit_timeout: cfg_update=0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hold = 1'b0; s_valid = 1'b0;
    exp_q.delete(); cur = '0;
    #2;
    vectors++;
    if ({cfg_valid, cfg_update, err, s_ready} !== 4'b0001 || pack_set() !== frame_t'('0)) begin
      miscompares++;
      $display("FAIL reset_state: valid/upd/err/rdy=%b set=%h required 0001 and 0",
               {cfg_valid, cfg_update, err, s_ready}, pack_set());
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    send_words(fa, NS);
    exp_q.push_back(fa);
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b0 || cfg_update !== 1'b0) begin
      miscompares++;
      $display("FAIL pend_cycle: s_ready=%b cfg_update=%b required 0 0", s_ready, cfg_update);
    end
    @(negedge clk);
    vectors++;
    if (cfg_update !== 1'b1 || cfg_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_latency: cfg_update=%b cfg_valid=%b required 1 1", cfg_update, cfg_valid);
    end
    @(negedge clk);
    vectors++;
    if (cfg_update !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL update_pulse: cfg_update=%b s_ready=%b required 0 1", cfg_update, s_ready);
    end
  endtask

  task automatic test_readback();
`ifdef BENES_CFG_READBACK_EN
    rd_idx = 3'd2;
    @(negedge clk);
    vectors++;
    if (rd_data !== 8'h69) begin
      miscompares++;
      $display("FAIL readback_2: got %h required 69", rd_data);
    end
    rd_idx = 3'd7;
    @(negedge clk);
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL readback_7: got %h required 00", rd_data);
    end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < NS - 1; k++) beat(fa[k], 1'b0);
    hold = 1'b1;
    beat(fa[NS-1], 1'b1);
    exp_q.push_back(fa);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (s_ready !== 1'b0 || cfg_update !== 1'b0 || pack_set() !== frame_t'('0)) begin
        miscompares++;
        $display("FAIL hold_defer: s_ready=%b cfg_update=%b set=%h required 0 0 0",
                 s_ready, cfg_update, pack_set());
      end
    end
    hold = 1'b0;
    @(negedge clk);
    vectors++;
    if (cfg_update !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: cfg_update=%b required 1", cfg_update);
    end
    @(negedge clk);
  endtask

  task automatic test_short_frame();
    send_words(fb, 3);
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || pack_set() !== cur || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL short_frame: err=%b set=%h rdy=%b required 1 %h 1", err, pack_set(), s_ready, cur);
    end
    send_words(fb, NS);
    exp_q.push_back(fb);
    wait_commit();
  endtask

  task automatic test_long_frame();
    do_reset();
    send_words(fb, NS + 2);
    @(negedge clk);
    vectors++;
    if (err !== 1'b1 || cfg_valid !== 1'b0 || pack_set() !== frame_t'('0)) begin
      miscompares++;
      $display("FAIL long_frame: err=%b valid=%b set=%h required 1 0 0", err, cfg_valid, pack_set());
    end
    send_words(fa, NS);
    exp_q.push_back(fa);
    wait_commit();
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 4; k++) beat(fb[k], 1'b0);
    do_reset();
    for (int k = 4; k < NS; k++) beat(fb[k], (k == NS - 1));
    repeat (4) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || cfg_valid !== 1'b0 || pack_set() !== frame_t'('0)) begin
      miscompares++;
      $display("FAIL reset_mid_frame: err=%b valid=%b set=%h required 1 0 0", err, cfg_valid, pack_set());
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NS; k++) f[k] = W'($urandom_range(0, 255));
      send_words(f, NS);
      exp_q.push_back(f);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || pack_set() !== f) begin
      miscompares++;
      $display("FAIL back_to_back: pending=%0d set=%h required 0 %h", exp_q.size(), pack_set(), f);
    end
  endtask

  initial begin
    fa = '0; fb = '0;
    fa[0] = 8'h0E; fa[1] = 8'h3C; fa[2] = 8'h69; fa[3] = 8'h69;
    fa[4] = 8'h55; fa[5] = 8'h55; fa[6] = 8'h55;
    for (int k = 0; k < NS; k++) fb[k] = W'(8'h11 * (k + 1));
    test_reset();
    test_basic();
    test_readback();
    test_hold();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
